cp_correlator: RTL
==================

Name: cp_correlator

Overview:
- Upstream front end of the CP-based timing/CFO estimator.
- Consumes the complex baseband sample stream and produces, per accepted sample, three sliding-window sums over the last L samples:
  - correlation real/imag: sum of x(m)·conj(x(m−N))
  - energy: sum of |x(m)|²+|x(m−N)|²
- Outputs are scaled and saturated to drive the sum_r/sum_i/sum_e inputs of the downstream CORDIC/argmax tracker directly.

Parameters:
- WL_SAMP, 12, signed width of each input sample component (I and Q).
- N_DLY, 64, correlation lag in samples (FFT length).
- L_WIN, 16, window length in samples (CP length); power of two.
- OUT_SHIFT, 5, arithmetic right shift from accumulator to output.
- WL_OUT, 24, signed output width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of fill counter, delay lines, FIFO and accumulators.
- in_valid  in  1  sample qualifier; the pipeline advances only on cycles with in_valid=1.
- r_in  in  WL_SAMP  signed I sample.
- i_in  in  WL_SAMP  signed Q sample.
- out_valid  out  1  output sums valid.
- sum_r  out  WL_OUT  signed correlation real part.
- sum_i  out  WL_OUT  signed correlation imaginary part.
- sum_e  out  WL_OUT  signed, always ≥0, energy sum.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0, out_valid=0.
  - delay lines, product FIFO, accumulators and fill counter cleared.
- Sample delay line: N_DLY-deep complex (I and Q) buffer, circular pointer or shift register.
  - On each in_valid, d = the sample accepted N_DLY valid cycles earlier; the new sample is then written.
  - Unwritten entries read as 0.
- Stage 1 (registered on in_valid):
  - pr = xr·dr + xi·di
  - pi = xi·dr − xr·di
  - pe = xr²+xi²+dr²+di²
  - Full precision: 2·WL_SAMP+1 bits for pr/pi, 2·WL_SAMP+2 bits for pe.
- Product FIFO: L_WIN-deep store of (pr, pi, pe), zero-initialised. The FIFO output is the entry being retired.
- Stage 2 (accumulate): acc += new − retired, applied to each of the three components.
  - Accumulator width is product width + log2(L_WIN).
  - The accumulator never overflows by construction.
- Output: out = acc >>> OUT_SHIFT, saturated to [−2^(WL_OUT−1), 2^(WL_OUT−1)−1], registered.
- Latency: out_valid and data are asserted exactly 2 clk cycles after the accepting in_valid cycle.
  - Gaps in in_valid produce matching gaps in out_valid; there are no bubbles otherwise.
- Warm-up: a fill counter counts accepted samples and saturates at N_DLY+L_WIN.
  - out_valid is suppressed until the sample with index k=N_DLY+L_WIN (1-based) has been accepted.
  - After that, every accepted sample yields out_valid.
  - Data registers still update during warm-up, with out_valid=0.
- clear:
  - Same effect as reset on the next edge; outputs go to 0 and in-flight valids are dropped.
  - If clear and in_valid are asserted together, clear wins and the sample is discarded.
- Output registers hold their value when no new valid arrives.

Test Plan:
- Reset, then 80 samples of (100,0) at full rate:
  - out_valid first high 2 cycles after sample 80.
  - sum_r=5000, sum_i=0, sum_e=10000.
  - Identical values on every later sample.
- 64 samples of (100,0) followed by (0,100):
  - At sample 80: sum_r=0, sum_i=5000, sum_e=10000.
- Constant (−2048,−2048) for 100 samples:
  - sum_r=4194304, sum_i=0.
  - sum_e saturates to 8388607.
- Same stream as the first scenario, but in_valid toggled 1/0 each cycle:
  - Identical output values.
  - out_valid pulses 2 cycles after each accepted sample; the first pulse follows the 80th accepted sample.
- Mid-stream rst low for 1 cycle at sample 90:
  - Outputs and out_valid go to 0 immediately.
  - After release, out_valid stays low until 80 new samples have been accepted.
- clear asserted with in_valid at sample 85:
  - Sample discarded, no out_valid for it.
  - Next out_valid follows 80 further samples.

Source files
------------

// File: rtl/cp_correlator.sv
// cp_correlator -- cyclic-prefix correlator front end.
//
// For every accepted complex sample x(m) this block produces three sliding
// sums over the last L_WIN samples, ready for the CORDIC/argmax tracker:
//   sum_r + j*sum_i = sum x(m) * conj(x(m-N_DLY))
//   sum_e           = sum |x(m)|^2 + |x(m-N_DLY)|^2
// Each sum is arithmetically shifted right by OUT_SHIFT and saturated to
// WL_OUT bits. Outputs appear two clock edges after the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   clear     synchronous flush of all state; overrides in_valid
//   in_valid  sample qualifier
//   r_in/i_in signed I/Q sample, WL_SAMP bits each
//   out_valid output qualifier, low during warm-up (first N_DLY+L_WIN-1 samples)
//   sum_r/sum_i/sum_e  signed WL_OUT-bit sums (sum_e never negative)

module cp_correlator #(
    parameter int WL_SAMP   = 12,
    parameter int N_DLY     = 64,
    parameter int L_WIN     = 16,
    parameter int OUT_SHIFT = 5,
    parameter int WL_OUT    = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic signed [WL_SAMP-1:0] r_in,
    input  logic signed [WL_SAMP-1:0] i_in,
    output logic                      out_valid,
    output logic signed [WL_OUT-1:0]  sum_r,
    output logic signed [WL_OUT-1:0]  sum_i,
    output logic signed [WL_OUT-1:0]  sum_e
);

    localparam int PW    = 2 * WL_SAMP + 1;
    localparam int EW    = 2 * WL_SAMP + 2;
    localparam int LOG_L = $clog2(L_WIN);
    localparam int ACW   = PW + LOG_L;
    localparam int AEW   = EW + LOG_L;
    localparam int DP_W  = $clog2(N_DLY);
    localparam int FP_W  = (LOG_L > 0) ? LOG_L : 1;
    localparam int CNT_W = $clog2(N_DLY + L_WIN + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_DLY + L_WIN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DLY + L_WIN - 1);

    localparam logic signed [AEW-1:0] SAT_HI = AEW'((64'sd1 <<< (WL_OUT - 1)) - 64'sd1);
    localparam logic signed [AEW-1:0] SAT_LO = AEW'(-(64'sd1 <<< (WL_OUT - 1)));

    function automatic logic signed [WL_OUT-1:0] scale_sat(input logic signed [AEW-1:0] a);
        logic signed [AEW-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > SAT_HI)
            return SAT_HI[WL_OUT-1:0];
        else if (s < SAT_LO)
            return SAT_LO[WL_OUT-1:0];
        else
            return s[WL_OUT-1:0];
    endfunction

    // ---------------------------------------------------------------
    // Delay line, fill counter and lagged-sample products
    // ---------------------------------------------------------------
    logic signed [WL_SAMP-1:0] dl_r [N_DLY];
    logic signed [WL_SAMP-1:0] dl_i [N_DLY];
    logic [DP_W-1:0]           dptr;
    logic [CNT_W-1:0]          cnt;

    logic signed [WL_SAMP-1:0] dr, di;
    logic signed [PW-1:0]      xr_pw, xi_pw, dr_pw, di_pw;
    logic signed [EW-1:0]      xr_ew, xi_ew, dr_ew, di_ew;
    logic signed [PW-1:0]      pr_c, pi_c;
    logic signed [EW-1:0]      pe_c;

    // The slot about to be overwritten holds the sample from N_DLY accepts ago.
    assign dr = dl_r[dptr];
    assign di = dl_i[dptr];

    assign xr_pw = {{(PW-WL_SAMP){r_in[WL_SAMP-1]}}, r_in};
    assign xi_pw = {{(PW-WL_SAMP){i_in[WL_SAMP-1]}}, i_in};
    assign dr_pw = {{(PW-WL_SAMP){dr[WL_SAMP-1]}}, dr};
    assign di_pw = {{(PW-WL_SAMP){di[WL_SAMP-1]}}, di};
    assign xr_ew = {{(EW-WL_SAMP){r_in[WL_SAMP-1]}}, r_in};
    assign xi_ew = {{(EW-WL_SAMP){i_in[WL_SAMP-1]}}, i_in};
    assign dr_ew = {{(EW-WL_SAMP){dr[WL_SAMP-1]}}, dr};
    assign di_ew = {{(EW-WL_SAMP){di[WL_SAMP-1]}}, di};

    assign pr_c = xr_pw * dr_pw + xi_pw * di_pw;
    assign pi_c = xi_pw * dr_pw - xr_pw * di_pw;
    assign pe_c = xr_ew * xr_ew + xi_ew * xi_ew + dr_ew * dr_ew + di_ew * di_ew;

    logic                 vld_p1;
    logic                 warm_p1;
    logic signed [PW-1:0] pr_p1, pi_p1;
    logic signed [EW-1:0] pe_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dptr    <= '0;
            cnt     <= '0;
            vld_p1  <= 1'b0;
            warm_p1 <= 1'b0;
            for (int k = 0; k < N_DLY; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else if (clear) begin
            dptr    <= '0;
            cnt     <= '0;
            vld_p1  <= 1'b0;
            warm_p1 <= 1'b0;
            for (int k = 0; k < N_DLY; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else begin
            vld_p1  <= in_valid;
            // Sample N_DLY+L_WIN is the first whose window is fully populated.
            warm_p1 <= in_valid && (cnt >= CNT_LAST);
            if (in_valid) begin
                dl_r[dptr] <= r_in;
                dl_i[dptr] <= i_in;
                dptr       <= (dptr == DP_W'(N_DLY - 1)) ? '0 : dptr + 1'b1;
                if (cnt != CNT_FULL)
                    cnt <= cnt + 1'b1;
            end
        end
    end

    // Product registers only matter while vld_p1 is set, so they need no flush.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            pr_p1 <= pr_c;
            pi_p1 <= pi_c;
            pe_p1 <= pe_c;
        end
    end

    // ---------------------------------------------------------------
    // Window FIFO, running accumulators, scaled/saturated outputs
    // ---------------------------------------------------------------
    logic signed [PW-1:0]  fifo_r [L_WIN];
    logic signed [PW-1:0]  fifo_i [L_WIN];
    logic signed [EW-1:0]  fifo_e [L_WIN];
    logic [FP_W-1:0]       fptr;
    logic signed [ACW-1:0] acc_r, acc_i;
    logic signed [AEW-1:0] acc_e;
    logic signed [ACW-1:0] acc_r_nx, acc_i_nx;
    logic signed [AEW-1:0] acc_e_nx;
    logic signed [PW-1:0]  ret_r, ret_i;
    logic signed [EW-1:0]  ret_e;

    assign ret_r = fifo_r[fptr];
    assign ret_i = fifo_i[fptr];
    assign ret_e = fifo_e[fptr];

    always_comb begin
        acc_r_nx = acc_r + {{LOG_L{pr_p1[PW-1]}}, pr_p1} - {{LOG_L{ret_r[PW-1]}}, ret_r};
        acc_i_nx = acc_i + {{LOG_L{pi_p1[PW-1]}}, pi_p1} - {{LOG_L{ret_i[PW-1]}}, ret_i};
        acc_e_nx = acc_e + {{LOG_L{pe_p1[EW-1]}}, pe_p1} - {{LOG_L{ret_e[EW-1]}}, ret_e};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fptr      <= '0;
            acc_r     <= '0;
            acc_i     <= '0;
            acc_e     <= '0;
            out_valid <= 1'b0;
            sum_r     <= '0;
            sum_i     <= '0;
            sum_e     <= '0;
            for (int k = 0; k < L_WIN; k++) begin
                fifo_r[k] <= '0;
                fifo_i[k] <= '0;
                fifo_e[k] <= '0;
            end
        end else if (clear) begin
            fptr      <= '0;
            acc_r     <= '0;
            acc_i     <= '0;
            acc_e     <= '0;
            out_valid <= 1'b0;
            sum_r     <= '0;
            sum_i     <= '0;
            sum_e     <= '0;
            for (int k = 0; k < L_WIN; k++) begin
                fifo_r[k] <= '0;
                fifo_i[k] <= '0;
                fifo_e[k] <= '0;
            end
        end else begin
            out_valid <= vld_p1 && warm_p1;
            if (vld_p1) begin
                fifo_r[fptr] <= pr_p1;
                fifo_i[fptr] <= pi_p1;
                fifo_e[fptr] <= pe_p1;
                fptr         <= (fptr == FP_W'(L_WIN - 1)) ? '0 : fptr + 1'b1;
                acc_r        <= acc_r_nx;
                acc_i        <= acc_i_nx;
                acc_e        <= acc_e_nx;
                sum_r <= scale_sat({{(AEW-ACW){acc_r_nx[ACW-1]}}, acc_r_nx});
                sum_i <= scale_sat({{(AEW-ACW){acc_i_nx[ACW-1]}}, acc_i_nx});
                sum_e <= scale_sat(acc_e_nx);
            end
        end
    end

endmodule
